// File: rtl/cla_seq_if.sv
// Request/response bundle for cla_add_sequencer: two operand requesters and one result consumer.
// rsp_ovf is present only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_id;
`ifdef CLA_SEQ_OVF_EN
    logic             rsp_ovf;
`endif

    // Producer/consumer side of the bundle
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef CLA_SEQ_OVF_EN
        , input rsp_ovf
`endif
    );

    // Sequencer side of the bundle
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef CLA_SEQ_OVF_EN
        , output rsp_ovf
`endif
    );
endinterface

// File: rtl/cla_add_sequencer.sv
// Two-requester round-robin sequencer running WIDTH-bit adds as serial 16-bit CLA beats.
// Optional macro CLA_SEQ_OVF_EN adds the registered two's-complement overflow output rsp_ovf.
module cla_add_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    cla_seq_if.slave  bus
);
    localparam int unsigned BEATS  = WIDTH / 16;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                id_q, id_d;
    logic                rr_q, rr_d;
    logic                valid_q, valid_d;
`ifdef CLA_SEQ_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    logic                grant0_c, grant1_c, accept_c, last_c;
    logic [15:0]         s_c;
    logic                cout_c;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_q
    assign grant0_c = bus.req0_valid & (~bus.req1_valid | ~rr_q);
    assign grant1_c = bus.req1_valid & (~bus.req0_valid |  rr_q);

    assign bus.req0_ready = rst_n & (state_q == S_IDLE) & grant0_c;
    assign bus.req1_ready = rst_n & (state_q == S_IDLE) & grant1_c;
    assign accept_c       = bus.req0_ready | bus.req1_ready;
    assign last_c         = (beat_q == BEAT_W'(BEATS - 1));

    // 16-bit slice: 4-bit group generate/propagate with lookahead across groups
    always_comb begin : cla_slice
        logic [15:0] x, y, bg, bp, c;
        logic [3:0]  gg, gp, gc;
        x  = '0;
        y  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                x = a_q[16*k +: 16];
                y = b_q[16*k +: 16];
            end
        end
        bg = x & y;
        bp = x ^ y;
        for (int unsigned j = 0; j < 4; j++) begin
            gg[j] = bg[4*j+3] | (bp[4*j+3] & bg[4*j+2])
                  | (bp[4*j+3] & bp[4*j+2] & bg[4*j+1])
                  | ((&bp[4*j+1 +: 3]) & bg[4*j]);
            gp[j] = &bp[4*j +: 4];
        end
        gc[0] = carry_q;
        gc[1] = gg[0] | (gp[0] & carry_q);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & carry_q);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & carry_q);
        for (int unsigned j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int unsigned i = 0; i < 3; i++) begin
                c[4*j+i+1] = bg[4*j+i] | (bp[4*j+i] & c[4*j+i]);
            end
        end
        s_c    = bp ^ c;
        cout_c = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & carry_q);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c)      state_d = S_RUN;
            S_RUN:   if (last_c)        state_d = S_DONE;
            S_DONE:  if (bus.rsp_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // FSM outputs: operand capture, beat sequencing and result hold
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        beat_d  = beat_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        rr_d    = rr_q;
        valid_d = valid_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    id_d    = grant1_c;
                    rr_d    = ~grant1_c;
                    a_d     = grant1_c ? bus.req1_a   : bus.req0_a;
                    b_d     = grant1_c ? bus.req1_b   : bus.req0_b;
                    carry_d = grant1_c ? bus.req1_cin : bus.req0_cin;
                    beat_d  = '0;
                end
            end
            S_RUN: begin
                for (int unsigned k = 0; k < BEATS; k++) begin
                    if (beat_q == BEAT_W'(k)) sum_d[16*k +: 16] = s_c;
                end
                carry_d = cout_c;
                beat_d  = beat_q + BEAT_W'(1);
                if (last_c) begin
                    cout_d  = cout_c;
                    valid_d = 1'b1;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s_c[15] != a_q[WIDTH-1]);
`endif
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            beat_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
            valid_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            beat_q  <= beat_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_id    = id_q;
`ifdef CLA_SEQ_OVF_EN
    assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer (WIDTH=32); overflow vectors run when CLA_SEQ_OVF_EN is defined.
module tb_cla_add_sequencer;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_seq_if #(.WIDTH(W)) bus ();

    cla_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] r_sum;
    logic        r_cout;
    logic        r_id;
    int          r_cyc;
`ifdef CLA_SEQ_OVF_EN
    logic        r_ovf;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic cin);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic wait_grant(input int who, output int got_who, output int at_cyc);
        bit seen = 1'b0;
        got_who = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                got_who = bus.req1_ready ? 1 : 0;
                check_val("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                seen = 1'b1;
            end
            @(negedge clk);
        end
        at_cyc = cyc;
        check_val("grant_seen", 32'(seen), 32'd1);
        if (who != 2) check_val("grant_who", 32'(got_who), 32'(who));
    endtask

    // Called at a falling edge; captures the response and returns one falling edge later.
    task automatic wait_rsp();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (bus.rsp_valid) begin
                r_sum  = bus.rsp_sum;
                r_cout = bus.rsp_cout;
                r_id   = bus.rsp_id;
`ifdef CLA_SEQ_OVF_EN
                r_ovf  = bus.rsp_ovf;
`endif
                r_cyc  = cyc;
                seen   = 1'b1;
            end
            @(negedge clk);
        end
        check_val("rsp_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string tag, input int port, input logic [31:0] a,
                          input logic [31:0] b, input logic cin,
                          input logic [31:0] exp_sum, input logic exp_cout);
        int who, acc;
        set_req(port, 1'b1, a, b, cin);
        wait_grant(port, who, acc);
        set_req(port, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_rsp();
        check_val({tag, "_sum"},  r_sum, exp_sum);
        check_val({tag, "_cout"}, 32'(r_cout), 32'(exp_cout));
        check_val({tag, "_id"},   32'(r_id), 32'(port));
        check_val({tag, "_lat"},  32'(r_cyc - acc), 32'd2);
    endtask

    initial begin
        int who, acc;
        int accs [3];
        bit seen;

        // Reset state with both requesters asserting valid
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b1, 32'd0, 32'd0, 1'b0);
        #1;
        check_val("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check_val("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check_val("rst_valid",  32'(bus.rsp_valid),  32'd0);
        check_val("rst_sum",    bus.rsp_sum,         32'd0);
        check_val("rst_cout",   32'(bus.rsp_cout),   32'd0);
        check_val("rst_id",     32'(bus.rsp_id),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Both valid straight out of reset: grants alternate 0,1,0,1
        set_req(0, 1'b1, 32'd1,  32'd2,  1'b0);
        set_req(1, 1'b1, 32'd10, 32'd20, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_grant(2, who, acc);
            check_val("rr_order", 32'(who), 32'(i % 2));
            wait_rsp();
            check_val("rr_rsp_id",  32'(r_id), 32'(i % 2));
            check_val("rr_rsp_sum", r_sum, (i % 2 == 1) ? 32'd31 : 32'd3);
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);

        // Carry across the beat boundary and a full ripple
        run_op("carry", 0, 32'h0001FFFF, 32'h00000001, 1'b0, 32'h00020000, 1'b0);
        run_op("ripple", 1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);

        // Lone requester served back-to-back every 4 edges
        set_req(0, 1'b1, 32'h00000100, 32'h00000200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_grant(0, who, accs[i]);
            wait_rsp();
            check_val("lone_sum", r_sum, 32'h00000300);
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_val("lone_ii_a", 32'(accs[1] - accs[0]), 32'd4);
        check_val("lone_ii_b", 32'(accs[2] - accs[1]), 32'd4);

        // Backpressure in DONE: result held, no request accepted
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'h12345678, 32'h11111111, 1'b1);
        wait_grant(1, who, acc);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_rsp();
        check_val("bp_sum0", r_sum, 32'h2345678A);
        set_req(0, 1'b1, 32'd7, 32'd7, 1'b0);
        set_req(1, 1'b1, 32'd7, 32'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_valid",  32'(bus.rsp_valid),  32'd1);
            check_val("bp_sum",    bus.rsp_sum,         32'h2345678A);
            check_val("bp_cout",   32'(bus.rsp_cout),   32'd0);
            check_val("bp_id",     32'(bus.rsp_id),     32'd1);
            check_val("bp_ready0", 32'(bus.req0_ready), 32'd0);
            check_val("bp_ready1", 32'(bus.req1_ready), 32'd0);
            @(negedge clk);
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check_val("bp_release", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);

        // Reset during RUN beat 0 aborts the operation and clears rr_ptr
        set_req(0, 1'b1, 32'd5, 32'd3, 1'b0);
        wait_grant(0, who, acc);
        rst_n = 1'b0;
        #1;
        check_val("abort_valid",  32'(bus.rsp_valid),  32'd0);
        check_val("abort_sum",    bus.rsp_sum,         32'd0);
        check_val("abort_cout",   32'(bus.rsp_cout),   32'd0);
        check_val("abort_id",     32'(bus.rsp_id),     32'd0);
        check_val("abort_ready0", 32'(bus.req0_ready), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check_val("abort_no_rsp", 32'(seen), 32'd0);
        set_req(0, 1'b1, 32'd5, 32'd3, 1'b0);
        set_req(1, 1'b1, 32'hFFFF0000, 32'h00010000, 1'b0);
        wait_grant(2, who, acc);
        check_val("abort_rr", 32'(who), 32'd0);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_rsp();
        check_val("post_r0_sum", r_sum, 32'd8);
        check_val("post_r0_id",  32'(r_id), 32'd0);
        wait_grant(1, who, acc);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_rsp();
        check_val("post_r1_sum",  r_sum, 32'd0);
        check_val("post_r1_cout", 32'(r_cout), 32'd1);
        check_val("post_r1_id",   32'(r_id), 32'd1);
        check_val("post_r1_lat",  32'(r_cyc - acc), 32'd2);

`ifdef CLA_SEQ_OVF_EN
        // Signed overflow flag
        run_op("ovf_pos", 0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0);
        check_val("ovf_pos_ovf", 32'(r_ovf), 32'd1);
        run_op("ovf_neg", 1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        check_val("ovf_neg_ovf", 32'(r_ovf), 32'd1);
        run_op("ovf_none", 0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0);
        check_val("ovf_none_ovf", 32'(r_ovf), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
